// File: rtl/seg_pkg.sv
// Shared types, default constants and saturation helpers for the
// inertial front end and the balance controller.
package seg_pkg;

  typedef enum logic {CAL, RUN} fusion_state_t;

  localparam logic signed [15:0] AZ_OFFSET_DEF   = 16'sh00A0;
  localparam int                 ACC_SCALE_DEF   = 327;
  localparam int                 FUSION_GAIN_DEF = 1024;

  // Clamp a 17-bit signed intermediate into the 16-bit signed range.
  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    if (v[16] != v[15]) return v[16] ? 16'sh8000 : 16'sh7FFF;
    return v[15:0];
  endfunction

  function automatic logic signed [26:0] sat27(input logic signed [27:0] v);
    if (v[27] != v[26]) return v[27] ? {1'b1, 26'd0} : {1'b0, {26{1'b1}}};
    return v[26:0];
  endfunction

endpackage

// File: rtl/gyro_offset_cal.sv
// Gyro zero-rate calibration: averages 2^CAL_LOG2 raw samples into an offset.
// The offset survives clr so the pipeline keeps a usable value until the next average lands.
module gyro_offset_cal #(
  parameter int CAL_LOG2 = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               smpl_vld,
  input  logic signed [15:0] ptch_rt_raw,
  input  logic               clr,
  output logic signed [15:0] offset,
  output logic               done
);

  localparam int AW = 16 + CAL_LOG2;

  logic signed [AW-1:0]  acc;
  logic signed [AW-1:0]  acc_sum;
  logic [CAL_LOG2-1:0]   cnt;

  assign acc_sum = acc + $signed({{CAL_LOG2{ptch_rt_raw[15]}}, ptch_rt_raw});

  // Done is combinational so the FSM can leave CAL on the edge that takes the last sample.
  assign done = smpl_vld & ~clr & (cnt == {CAL_LOG2{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      cnt    <= '0;
      offset <= '0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (smpl_vld) begin
      if (done) begin
        acc    <= '0;
        cnt    <= '0;
        offset <= acc_sum[CAL_LOG2 +: 16];
      end else begin
        acc <= acc_sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ptch_fusion.sv
// Inertial front end: gyro offset calibration, then a 3-stage complementary
// filter fusing gyro rate and accelerometer pitch for the balance controller.
module ptch_fusion
  import seg_pkg::*;
#(
  parameter int                 CAL_LOG2    = 4,
  parameter int                 FUSION_GAIN = FUSION_GAIN_DEF,
  parameter logic signed [15:0] AZ_OFFSET   = AZ_OFFSET_DEF,
  parameter int                 ACC_SCALE   = ACC_SCALE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               smpl_vld,
  input  logic signed [15:0] ptch_rt_raw,
  input  logic signed [15:0] AZ,
  input  logic               recal,
  output logic signed [15:0] ptch,
  output logic signed [15:0] ptch_rt,
  output logic               vld,
  output logic               cal_done
);

  fusion_state_t state, state_nxt;

  logic               cal_vld;
  logic               cal_last;
  logic               run_smpl;
  logic signed [15:0] gyro_offset;

  logic signed [16:0] rt_diff;
  logic signed [16:0] az_diff;
  logic               s1_vld;
  logic signed [15:0] rt_c1;
  logic signed [15:0] az_c1;

  logic signed [25:0] acc_prod;
  logic               s2_vld;
  logic signed [15:0] rt_c2;
  logic signed [15:0] ptch_acc2;

  logic signed [27:0] corr;
  logic signed [27:0] int_sum;
  logic signed [26:0] int_next;
  logic signed [26:0] ptch_int;

  assign cal_vld  = smpl_vld & (state == CAL);
  assign run_smpl = smpl_vld & (state == RUN) & ~recal;
  assign cal_done = (state == RUN);

  gyro_offset_cal #(.CAL_LOG2(CAL_LOG2)) u_cal (
    .clk        (clk),
    .rst_n      (rst_n),
    .smpl_vld   (cal_vld),
    .ptch_rt_raw(ptch_rt_raw),
    .clr        (recal),
    .offset     (gyro_offset),
    .done       (cal_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CAL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CAL:     if (cal_last) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = CAL;
    endcase
    if (recal) state_nxt = CAL;
  end

  // S1: offset and zero compensation at 17 bits, then clamp.
  assign rt_diff = $signed({ptch_rt_raw[15], ptch_rt_raw}) - $signed({gyro_offset[15], gyro_offset});
  assign az_diff = $signed({AZ[15], AZ}) - $signed({AZ_OFFSET[15], AZ_OFFSET});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      rt_c1  <= '0;
      az_c1  <= '0;
    end else begin
      s1_vld <= run_smpl;
      if (run_smpl) begin
        rt_c1 <= sat16(rt_diff);
        az_c1 <= sat16(az_diff);
      end
    end
  end

  // S2: accel-derived pitch estimate.
  assign acc_prod = 26'(az_c1) * 26'(ACC_SCALE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld    <= 1'b0;
      rt_c2     <= '0;
      ptch_acc2 <= '0;
    end else begin
      s2_vld <= s1_vld & ~recal;
      if (s1_vld) begin
        rt_c2     <= rt_c1;
        ptch_acc2 <= 16'(acc_prod >>> 13);
      end
    end
  end

  // S3: the accel estimate nudges the integrator towards itself by a fixed step.
  always_comb begin
    corr = '0;
    if (ptch_acc2 > ptch)      corr = 28'(FUSION_GAIN);
    else if (ptch_acc2 < ptch) corr = -28'(FUSION_GAIN);
  end

  assign int_sum  = 28'(ptch_int) - 28'(rt_c2) + corr;
  assign int_next = sat27(int_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptch_int <= '0;
      ptch     <= '0;
      ptch_rt  <= '0;
      vld      <= 1'b0;
    end else if (recal) begin
      ptch_int <= '0;
      ptch     <= '0;
      ptch_rt  <= '0;
      vld      <= 1'b0;
    end else begin
      vld <= s2_vld;
      if (s2_vld) begin
        ptch_int <= int_next;
        ptch     <= int_next[26:11];
        ptch_rt  <= rt_c2;
      end
    end
  end

endmodule

// File: doc/ptch_fusion.md
# ptch_fusion

Inertial front end for the balance controller. It consumes raw gyro pitch-rate and vertical-accelerometer samples and calibrates the gyro offset at start-up and on request. It fuses the two sources with a complementary filter and drives the `ptch`, `ptch_rt` and `vld` inputs of the PID balance block.

## Interface
Parameters:
- `CAL_LOG2`, default 4: calibration averages 2^CAL_LOG2 samples.
- `FUSION_GAIN`, default 1024: accel-correction step added to the integrator per sample.
- `AZ_OFFSET`, default 16'sh00A0: accelerometer zero offset.
- `ACC_SCALE`, default 327: accel-to-pitch multiplier, applied before `>>>13`.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `smpl_vld`  in  1  one-cycle strobe; raw sample inputs are valid this cycle.
- `ptch_rt_raw`  in  16 signed  raw gyro pitch rate.
- `AZ`  in  16 signed  raw vertical accel.
- `recal`  in  1  synchronous restart of calibration.
- `ptch`  out  16 signed  fused pitch.
- `ptch_rt`  out  16 signed  offset-compensated pitch rate.
- `vld`  out  1  one-cycle strobe; `ptch`/`ptch_rt` updated.
- `cal_done`  out  1  high while in RUN.

## Operation
- **FSM states:** CAL and RUN. Reset and `recal` both enter CAL with the accumulator, the sample count, `ptch_int` and the stage valids cleared.
- **CAL:**
  - Each `smpl_vld` adds sext(`ptch_rt_raw`) to a (16+CAL_LOG2)-bit accumulator and increments the count.
  - On the 2^CAL_LOG2-th sample: `gyro_offset <= (acc + raw) >>> CAL_LOG2`, then go to RUN.
  - No `vld` pulses are produced during CAL.
- **RUN:** fully pipelined; `smpl_vld` is accepted every cycle.
  - **S1:**
    - `rt_c = sat16(raw - gyro_offset)`, computed at 17 bits.
    - `az_c = sat16(AZ - AZ_OFFSET)`, computed at 17 bits.
  - **S2:**
    - `ptch_acc = (az_c * ACC_SCALE) >>> 13`, with a 26-bit signed product truncated to 16 bits.
    - `rt_c` is delayed by one stage alongside it.
  - **S3:**
    - `ptch_int` (27-bit signed) `<= sat27(ptch_int - sext(rt_c) + corr)`.
    - `corr` is +FUSION_GAIN if `ptch_acc > ptch`, −FUSION_GAIN if `ptch_acc < ptch`, and 0 if they are equal.
    - `ptch = ptch_int[26:11]`; `ptch_rt = rt_c`; `vld` pulses.
- **Saturation:** `ptch_int` clamps at ±(2^26−1 / −2^26) and never wraps.
- **`recal` priority:**
  - `recal` beats `smpl_vld` in the same cycle; that sample is discarded.
  - `recal` flushes the S1–S3 valids, so no `vld` is produced for in-flight samples.
  - It zeroes `ptch`, `ptch_rt` and `ptch_int`.
  - It drops `cal_done` the next cycle.
  - `gyro_offset` keeps its old value until the new calibration completes.
- **Between samples:** outputs hold their last values.

## Timing
- **Reset values:** `ptch`=0, `ptch_rt`=0, `vld`=0, `cal_done`=0, state=CAL, `gyro_offset`=0.
- **Latency:** a `smpl_vld` at cycle N in RUN gives `vld`=1 at N+3, with `ptch`/`ptch_rt` valid in that same cycle.
- **Throughput:** one sample per cycle.
- **Calibration completion:** `cal_done` rises the cycle after the final calibration sample. That sample does not produce `vld`; the first RUN sample is the next `smpl_vld`.
- **Reset mid-pipeline:** asynchronous clear of everything; no partial outputs.

## Structure
- **Package `seg_pkg`:**
  - `fusion_state_t` enum {CAL, RUN}.
  - Default constants `AZ_OFFSET`, `ACC_SCALE`, `FUSION_GAIN`.
  - `sat16` function, shared with the saturation logic in the balance controller.
- **Sub-module `gyro_offset_cal`:**
  - Contains the accumulator, the sample counter and the done pulse.
  - Inputs `smpl_vld`, `ptch_rt_raw`, `clr`; outputs `offset`, `done`.
  - The top-level contains the FSM, the S1–S3 pipeline and the integrator.

## Test plan
- **Reset/CAL:** from reset, 16 samples `raw`=0x0010, `AZ`=0x00A0 → no `vld`; `cal_done`=1 the cycle after the 16th; offset=0x0010.
- **Zero motion:** in RUN, `raw`=0x0010, `AZ`=0x00A0 on back-to-back strobes → `vld` at N+3 each cycle; `ptch`=0, `ptch_rt`=0.
- **Gyro step:**
  - One sample `raw`=0x0810 → `ptch_rt`=0x0800 and `ptch`=0xFFFF (−1).
  - Next, `raw`=0x0010 → `corr`=+1024; after 2 samples `ptch`=0.
- **Accel convergence:**
  - Hold `AZ`=0x20A0 (`az_c`=8192, `ptch_acc`=327), `raw`=offset.
  - Expect `ptch` to rise by 1 every 2 samples, reach 327 after 654 samples, then stay at 327.
- **Saturation:** `AZ`=0x8000 → `az_c` clamps to −32768 and `ptch_acc`=−1308; `raw`=0x8000 with offset 0x0010 → `rt_c`=−32768, no wrap.
- **Recal mid-pipeline:**
  - Assert `recal` with S1–S3 full and `smpl_vld` high → no further `vld`, `ptch`/`ptch_rt`=0, `cal_done`=0 the next cycle.
  - 16 new samples are then needed to return to RUN.
